// File: rtl/data_mem_arbiter.sv
// Two-port arbiter sharing one 256x8 data memory between the load/store unit (port 0)
// and the loader/debug port (port 1): combinational grant, registered read return.
module data_mem_arbiter #(
  parameter int unsigned FIXED_PRIO   = 0,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       CLK,
  input  logic       RST_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [7:0] addr0,
  input  logic [7:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  input  logic       lock0,
  input  logic       lock1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       rvalid0,
  output logic       rvalid1,
  output logic [7:0] rdata0,
  output logic [7:0] rdata1,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       mem_we,
  input  logic [7:0] mem_rdata
);

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;
  localparam int unsigned SW = 4;
  localparam logic [SW-1:0] STARVE_MAX = '1;
  localparam logic [SW-1:0] STARVE_THR = SW'(STARVE_LIMIT);
  localparam bit            FIXED      = (FIXED_PRIO != 0);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_P0   = 2'd1,
    OWN_P1   = 2'd2
  } owner_e;

  owner_e        owner;
  logic          last;
  logic [SW-1:0] starve;

  logic          win_vld_c;
  logic          win_c;
  logic          win_lock_c;

  // Winner selection: held lock first, then single requester, then RR / fixed with relief.
  always_comb begin
    win_vld_c = 1'b0;
    win_c     = 1'b0;
    if (owner == OWN_P0 && req0) begin
      win_vld_c = 1'b1;
      win_c     = 1'b0;
    end else if (owner == OWN_P1 && req1) begin
      win_vld_c = 1'b1;
      win_c     = 1'b1;
    end else if (req0 && !req1) begin
      win_vld_c = 1'b1;
      win_c     = 1'b0;
    end else if (req1 && !req0) begin
      win_vld_c = 1'b1;
      win_c     = 1'b1;
    end else if (req0 && req1) begin
      win_vld_c = 1'b1;
      if (FIXED) win_c = (starve >= STARVE_THR);
      else       win_c = ~last;
    end
    // No grants and no memory writes while reset is held.
    if (!RST_n) win_vld_c = 1'b0;
  end

  // Memory-side datapath mux.
  always_comb begin
    gnt0       = win_vld_c & ~win_c;
    gnt1       = win_vld_c &  win_c;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    win_lock_c = 1'b0;
    if (win_vld_c) begin
      if (win_c) begin
        mem_we     = we1;
        mem_addr   = AW'(addr1);
        mem_wdata  = DW'(wdata1);
        win_lock_c = lock1;
      end else begin
        mem_we     = we0;
        mem_addr   = AW'(addr0);
        mem_wdata  = DW'(wdata0);
        win_lock_c = lock0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      owner   <= OWN_NONE;
      last    <= 1'b1;
      starve  <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      if (win_vld_c) begin
        last <= win_c;
        if (win_lock_c) owner <= win_c ? OWN_P1 : OWN_P0;
        else            owner <= OWN_NONE;
        if (!mem_we) begin
          if (win_c) begin
            rvalid1 <= 1'b1;
            rdata1  <= mem_rdata;
          end else begin
            rvalid0 <= 1'b1;
            rdata0  <= mem_rdata;
          end
        end
      end else begin
        // No winner means the owner (if any) dropped its request.
        owner <= OWN_NONE;
      end
      // Refusal counter for port 1; only meaningful under fixed priority.
      if (!FIXED || !req1 || gnt1) starve <= '0;
      else if (starve != STARVE_MAX) starve <= starve + 4'd1;
    end
  end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-port arbiter that shares the single-port 256x8 data memory between the core load/store unit (port 0) and the memory loader/debug port (port 1). It grants at most one access per cycle and drives the memory's address, write-data and write-enable lines. It returns read data to the winning requester, registered, one cycle later. It supports round-robin or fixed priority with starvation relief, and a lock for back-to-back read-modify-write sequences.

## Interface
Parameters:
- FIXED_PRIO, default 0: 0 = round-robin between ports; 1 = port 0 preferred, with starvation relief for port 1.
- STARVE_LIMIT, default 4: the number of consecutive cycles port 1 may be refused in FIXED_PRIO mode before it is force-granted (range 1-15).

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST_n  in  1  asynchronous, active-low reset.
- req0 / req1  in  1  access request; held until the matching gnt is seen.
- we0 / we1  in  1  1 = write, 0 = read; valid while req is high.
- addr0 / addr1  in  8  memory address.
- wdata0 / wdata1  in  8  write data.
- lock0 / lock1  in  1  when high with a granted req, the port keeps ownership next cycle.
- gnt0 / gnt1  out  1  combinational grant; the transfer happens on the edge that closes the cycle where req&gnt=1.
- rvalid0 / rvalid1  out  1  one-cycle pulse; rdata is valid.
- rdata0 / rdata1  out  8  registered read data.
- mem_addr  out  8  to data memory address.
- mem_wdata  out  8  to data memory write data.
- mem_we  out  1  to data memory write enable.
- mem_rdata  in  8  from data memory; combinational read of mem_addr.

## Operation
- State registers:
  - `last`: the last winner, 0/1.
  - `owner`: NONE/P0/P1; non-NONE only while a lock is held.
  - `starve`: a 4-bit counter.
  - `rvalid0`, `rvalid1`, `rdata0`, `rdata1`.
- Winner selection each cycle, in priority order:
  1. If `owner` = Pn and reqn = 1, port n wins.
  2. Else if `owner` = Pn and reqn = 0, `owner` is treated as NONE.
  3. Else if only one port requests, that port wins.
  4. Else if both request and FIXED_PRIO = 0, the port other than `last` wins.
  5. Else if both request and FIXED_PRIO = 1, port 1 wins when `starve` >= STARVE_LIMIT; otherwise port 0 wins.
- Datapath mux:
  - With a winner: gnt of that port = 1, mem_addr = its addr, mem_wdata = its wdata, mem_we = its we.
  - Without a winner: all gnt = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Updates on each edge:
  - When there is a winner: `last` <= winner; `owner` <= winner if its lock = 1, else NONE.
  - If the winner performed a read: rdataN <= mem_rdata and rvalidN <= 1. All other rvalid <= 0.
  - `starve`: incremented (saturating at 15) when req1 = 1 and gnt1 = 0. Cleared when gnt1 = 1 or req1 = 0. It only counts in FIXED_PRIO = 1 and stays 0 otherwise.
- Lock behaviour:
  - A lock overrides starvation relief and round-robin.
  - A lock is released by lock = 0 on a granted cycle, or by the owner dropping req.
- Writes commit in memory on the same edge as the grant cycle. A read issued on the cycle after a write to the same address returns the new data.

## Timing
- Reset values (RST_n low, asynchronous): `owner` = NONE, `last` = 1 (so port 0 wins the first contention), `starve` = 0, rvalid0 = rvalid1 = 0, rdata0 = rdata1 = 0.
- While RST_n is low: gnt0 = gnt1 = 0 and mem_we = 0. No write occurs during reset.
- Reset asserted mid-lock: the lock is dropped. Reset asserted the cycle after a read: the pending rvalid is cleared, and that read is lost.
- Latency:
  - Grant is 0 cycles (combinational from req).
  - Write commits at the end of the grant cycle.
  - Read data appears one cycle after grant (rvalid pulse of exactly 1 cycle).
- Throughput is one access per cycle. Back-to-back grants to the same port are allowed.
- Requester rule: req, we, addr, wdata and lock are held stable until the cycle gnt = 1. Dropping req before grant is legal; the access is then abandoned with no side effects.

## Test plan
- Reset, then req0 writes 0x21 to addr 0x00, then req0 reads addr 0x00 → gnt0 = 1 in both cycles; rvalid0 pulses one cycle after the read with rdata0 = 0x21; mem_we = 1 for exactly one cycle.
- Round-robin (FIXED_PRIO = 0), req0 and req1 both reading continuously for 6 cycles → the first grant is gnt0, then grants alternate 0,1,0,1,0,1; the matching rvalid pulses appear one cycle after each grant.
- FIXED_PRIO = 1, STARVE_LIMIT = 4, both requesting continuously → gnt0 for 4 cycles, gnt1 on the 5th, then the pattern repeats; `starve` is 0 after each gnt1.
- lock0 held for 3 grants while req1 is also high → gnt0 for 3 consecutive cycles (read 0x2A, write 0x2A, read 0x2A), then gnt1 in the cycle after lock0 drops.
- Both ports write different data to addr 0x2B in the same cycle → only the winner's data is in memory; a later read returns that value.
- RST_n pulsed low while a lock is held and a read is outstanding → rvalid clears immediately and the lock is released; after release, port 0 wins the first contention.
